// File: rtl/wb_cpu_via_bridge_pkg.sv
// -----------------------------------------------------------------------------
// wb_cpu_via_bridge_pkg
// Types and constants shared by CPU-side Wishbone bus bridges.
//   bridge_state_e   : access sequencer states (IDLE=0, STROBE=1, WAIT=2, DONE=3)
//   OPEN_BUS_DEFAULT : read data returned when no slave answers
//   cnt_width()      : width of a counter that must hold values 0..limit
// -----------------------------------------------------------------------------
package wb_cpu_via_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } bridge_state_e;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

  // At least one bit, even for a degenerate limit of 0.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_cpu_via_bridge_if.sv
// -----------------------------------------------------------------------------
// wb_cpu_via_bridge_if
// Minimal single-strobe Wishbone link between the CPU bridge and one slave.
//   stb_o  : strobe, driven by the master
//   we_o   : write enable, driven by the master
//   adr_o  : register index, driven by the master
//   dat_o  : write data, driven by the master
//   dat_i  : read data, driven by the slave
//   ack_i  : acknowledge, driven by the slave
// Signal names are taken from the master's point of view.
// -----------------------------------------------------------------------------
interface wb_cpu_via_bridge_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();

  logic              stb_o;
  logic              we_o;
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              ack_i;

  modport master (
    output stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i
  );

endinterface

// File: rtl/wb_cpu_via_bridge.sv
// -----------------------------------------------------------------------------
// wb_cpu_via_bridge
// Turns 8-bit CPU load/store requests into single-strobe Wishbone accesses to
// a 16-register VIA. Requests inside the BASE_ADDR window are forwarded and
// the CPU is held until the slave acks; misses and slave timeouts return
// OPEN_BUS data. Timeouts raise a sticky error flag.
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-high reset
//   cpu_valid/cpu_we    : CPU request and direction (held until cpu_rdy)
//   cpu_addr/cpu_wdata  : CPU byte address and write data
//   cpu_rdata/cpu_rdy   : read data and one-cycle completion pulse
//   wb (master)         : Wishbone stb/we/adr/dat_o out, dat_i/ack in
//   timeout_o           : sticky slave-timeout flag
//   err_clr_i           : clears timeout_o (a new timeout takes priority)
// -----------------------------------------------------------------------------
module wb_cpu_via_bridge
  import wb_cpu_via_bridge_pkg::*;
#(
  parameter int                           CPU_ADDR_WIDTH = 16,
  parameter int                           WB_ADDR_WIDTH  = 4,
  parameter int                           WB_DATA_WIDTH  = 8,
  parameter logic [CPU_ADDR_WIDTH-1:0]    BASE_ADDR      = 16'h6000,
  parameter int                           TIMEOUT        = 15,
  parameter logic [WB_DATA_WIDTH-1:0]     OPEN_BUS       = OPEN_BUS_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cpu_valid,
  input  logic                      cpu_we,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WB_DATA_WIDTH-1:0]  cpu_wdata,
  output logic [WB_DATA_WIDTH-1:0]  cpu_rdata,
  output logic                      cpu_rdy,
  wb_cpu_via_bridge_if.master       wb,
  output logic                      timeout_o,
  input  logic                      err_clr_i
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bridge_state_e             state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      stb_q, stb_d;
  logic                      we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0]  adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0]  dat_q, dat_d;
  logic [WB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                      rdy_q, rdy_d;
  logic                      tmo_q, tmo_d;
  logic                      tmo_set;
  logic                      addr_hit;

  // Only the bits above the register index select the window.
  assign addr_hit = (cpu_addr[CPU_ADDR_WIDTH-1:WB_ADDR_WIDTH] ==
                     BASE_ADDR[CPU_ADDR_WIDTH-1:WB_ADDR_WIDTH]);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = 1'b0;        // strobe lives for exactly one cycle
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    tmo_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          if (addr_hit) begin
            we_d    = cpu_we;
            adr_d   = cpu_addr[WB_ADDR_WIDTH-1:0];
            if (cpu_we) dat_d = cpu_wdata;
            stb_d   = 1'b1;
            state_d = STROBE;
          end else begin
            rdata_d = OPEN_BUS;
            state_d = DONE;
          end
        end
      end
      STROBE: begin
        cnt_d = '0;
        // A combinational slave may ack in the strobe cycle itself.
        if (wb.ack_i) begin
          if (!we_q) rdata_d = wb.dat_i;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wb.ack_i) begin
          if (!we_q) rdata_d = wb.dat_i;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = OPEN_BUS;
          tmo_set = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Any ack arriving here is a stray; the CPU already has its answer.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // cpu_rdy is registered, so it is raised on the edge that enters DONE.
    rdy_d = (state_d == DONE);
    tmo_d = tmo_set | (tmo_q & ~err_clr_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign wb.stb_o  = stb_q;
  assign wb.we_o   = we_q;
  assign wb.adr_o  = adr_q;
  assign wb.dat_o  = dat_q;
  assign cpu_rdata = rdata_q;
  assign cpu_rdy   = rdy_q;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_wb_cpu_via_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_cpu_via_bridge
// Drives CPU requests into the bridge and answers the Wishbone side with a
// small 16-register VIA model whose ack behaviour is selectable (registered,
// combinational, silent). Expected completions go into a queue when a request
// is issued and are compared when cpu_rdy appears.
// -----------------------------------------------------------------------------
module tb_wb_cpu_via_bridge;

  typedef enum int {ACK_REG, ACK_COMB, ACK_NONE} ack_mode_e;

  typedef struct {
    logic [7:0] rdata;
    int         lat;     // negedges from the sampling edge until cpu_rdy
    int         stb;     // strobed cycles expected
    logic [3:0] adr;
    logic       we;
    logic [7:0] dat;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_valid;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        timeout_o;
  logic        err_clr_i;

  ack_mode_e   ack_mode;
  logic        stray_ack;
  logic        ack_q;
  logic [7:0]  dat_q;
  logic [7:0]  port_a;
  logic [7:0]  via_regs [16];

  exp_t        sb [$];
  logic [7:0]  last_rdata;
  logic [7:0]  last_dat;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_i = ~clk_i;

  wb_cpu_via_bridge_if #(.ADDR_W(4), .DATA_W(8)) wb ();

  wb_cpu_via_bridge dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cpu_valid (cpu_valid),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
    .wb        (wb.master),
    .timeout_o (timeout_o),
    .err_clr_i (err_clr_i)
  );

  // VIA model: register 1 (ORA) reads the port_a pins, the rest read back.
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) via_regs[i] <= 8'(8'h30 + i);
      ack_q <= 1'b0;
      dat_q <= 8'h00;
    end else begin
      ack_q <= 1'b0;
      if (wb.stb_o && ack_mode == ACK_REG) begin
        ack_q <= 1'b1;
        dat_q <= (wb.adr_o == 4'd1) ? port_a : via_regs[wb.adr_o];
      end
      if (wb.stb_o && wb.we_o && ack_mode != ACK_NONE)
        via_regs[wb.adr_o] <= wb.dat_o;
    end
  end

  always_comb begin
    wb.ack_i = stray_ack;
    wb.dat_i = dat_q;
    if (ack_mode == ACK_COMB) begin
      wb.ack_i = stray_ack | wb.stb_o;
      wb.dat_i = (wb.adr_o == 4'd1) ? port_a : via_regs[wb.adr_o];
    end else if (ack_mode == ACK_REG) begin
      wb.ack_i = stray_ack | ack_q;
    end
  end

  // One CPU access: push expectation, drive, wait for cpu_rdy, pop and compare.
  task automatic access(input logic we, input logic [15:0] addr,
                        input logic [7:0] wdata, input string name);
    exp_t e;
    int   n = 0;
    int   stb_seen = 0;
    logic done = 1'b0;
    logic hit;
    logic [3:0] adr_s = 4'h0;
    logic we_s = 1'b0;
    logic [7:0] dat_s = 8'h00;

    hit   = (addr[15:4] == 12'h600);
    e.adr = addr[3:0];
    e.we  = we;
    e.dat = we ? wdata : last_dat;
    e.stb = hit ? 1 : 0;
    if (!hit)                    e.rdata = 8'hFF;
    else if (we)                 e.rdata = last_rdata;
    else if (ack_mode == ACK_NONE) e.rdata = 8'hFF;
    else e.rdata = (addr[3:0] == 4'd1) ? port_a : via_regs[addr[3:0]];
    // Miss: DONE straight after the sampling edge. Hit: STROBE, then WAIT
    // (registered ack) or DONE (comb ack); silent slave: 15 WAIT cycles.
    if (!hit)                      e.lat = 1;
    else if (ack_mode == ACK_COMB) e.lat = 2;
    else if (ack_mode == ACK_REG)  e.lat = 3;
    else                           e.lat = 17;
    sb.push_back(e);

    @(negedge clk_i);
    cpu_valid = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    while (!done && n < 64) begin
      @(negedge clk_i);
      n++;
      if (wb.stb_o) begin
        stb_seen++;
        adr_s = wb.adr_o;
        we_s  = wb.we_o;
        dat_s = wb.dat_o;
      end
      if (cpu_rdy) done = 1'b1;
    end
    cpu_valid = 1'b0;
    err_clr_i = 1'b0;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s no_rdy: got no cpu_rdy within %0d cycles", name, n);
      void'(sb.pop_back());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (cpu_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h exp %h", name, cpu_rdata, e.rdata);
    end
    checks++;
    if (n !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d exp %0d", name, n, e.lat);
    end
    checks++;
    if (stb_seen !== e.stb) begin
      errors++;
      $display("FAIL %s stb_cycles: got %0d exp %0d", name, stb_seen, e.stb);
    end
    if (e.stb > 0) begin
      checks++;
      if (adr_s !== e.adr || we_s !== e.we || dat_s !== e.dat) begin
        errors++;
        $display("FAIL %s bus: got adr=%h we=%b dat=%h exp adr=%h we=%b dat=%h",
                 name, adr_s, we_s, dat_s, e.adr, e.we, e.dat);
      end
    end
    last_rdata = e.rdata;
    if (hit && we) last_dat = wdata;

    @(negedge clk_i);
    checks++;
    if (cpu_rdy !== 1'b0 || wb.stb_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got rdy=%b stb=%b exp 0 0", name, cpu_rdy, wb.stb_o);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o, cpu_rdata, cpu_rdy, timeout_o} !== '0) begin
      errors++;
      $display("FAIL %s: got stb=%b we=%b adr=%h dat=%h rdata=%h rdy=%b tmo=%b exp all 0",
               name, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o, cpu_rdata, cpu_rdy, timeout_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset_state");
    rst_i = 1'b0;
    last_rdata = 8'h00;
    last_dat   = 8'h00;
  endtask

  task automatic test_write_hit();
    ack_mode = ACK_REG;
    access(1'b1, 16'h6003, 8'hF0, "write_hit");
    checks++;
    if (via_regs[3] !== 8'hF0) begin
      errors++;
      $display("FAIL ddra_written: got %h exp f0", via_regs[3]);
    end
  endtask

  task automatic test_read_hit();
    ack_mode = ACK_REG;
    port_a   = 8'h5A;
    access(1'b0, 16'h6001, 8'h00, "read_hit");
  endtask

  task automatic test_miss();
    access(1'b0, 16'h7001, 8'h00, "miss_7001");
    access(1'b0, 16'h5FFF, 8'h00, "miss_below");
    access(1'b1, 16'h6010, 8'h77, "miss_above");
  endtask

  task automatic test_timeout();
    ack_mode = ACK_NONE;
    access(1'b0, 16'h6005, 8'h00, "timeout");
    repeat (3) @(negedge clk_i);
    checks++;
    if (timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b exp 1", timeout_o);
    end
    // Late ack with no request pending must not complete anything.
    ack_mode  = ACK_REG;
    stray_ack = 1'b1;
    @(negedge clk_i);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (cpu_rdy !== 1'b0 || cpu_rdata !== 8'hFF || wb.stb_o !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: got rdy=%b rdata=%h stb=%b exp 0 ff 0",
               cpu_rdy, cpu_rdata, wb.stb_o);
    end
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got %b exp 0", timeout_o);
    end
  endtask

  // err_clr_i held high for the whole access: the timeout edge must still set.
  task automatic test_timeout_set_wins();
    ack_mode  = ACK_NONE;
    err_clr_i = 1'b1;
    access(1'b0, 16'h6006, 8'h00, "timeout_clr_held");
    checks++;
    if (timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got %b exp 1", timeout_o);
    end
  endtask

  task automatic test_comb_ack();
    ack_mode = ACK_COMB;
    port_a   = 8'hA5;
    access(1'b0, 16'h6001, 8'h00, "comb_read");
    access(1'b1, 16'h600C, 8'h3E, "comb_write");
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [4] = '{16'h6000, 16'h600F, 16'h6007, 16'h600F};
    logic [7:0]  datas [4] = '{8'h11, 8'hEE, 8'h42, 8'h9C};
    ack_mode = ACK_REG;
    for (int i = 0; i < 4; i++) begin
      access(1'b1, addrs[i], datas[i], $sformatf("b2b_wr%0d", i));
      access(1'b0, addrs[i], 8'h00, $sformatf("b2b_rd%0d", i));
    end
  endtask

  task automatic test_reset_in_wait();
    ack_mode  = ACK_NONE;
    @(negedge clk_i);
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h6004;
    repeat (4) @(negedge clk_i);   // STROBE, then WAIT
    rst_i     = 1'b1;
    cpu_valid = 1'b0;
    @(negedge clk_i);
    check_outputs_zero("reset_in_wait");
    rst_i      = 1'b0;
    last_rdata = 8'h00;
    last_dat   = 8'h00;
    ack_mode   = ACK_REG;
    access(1'b0, 16'h6002, 8'h00, "read_after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish exp finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i     = 1'b1;
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    err_clr_i = 1'b0;
    stray_ack = 1'b0;
    ack_mode  = ACK_REG;
    port_a    = 8'h00;

    test_reset();
    test_write_hit();
    test_read_hit();
    test_miss();
    test_timeout();
    test_comb_ack();
    test_back_to_back();
    test_timeout_set_wins();
    test_reset_in_wait();

    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
